// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor table and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DIV_W = 14;

    // clk cycles per sample tick at 50 MHz, indexed by baud_select
    localparam logic [DIV_W-1:0] BAUD_DIVISOR [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326,
        14'd163,   14'd81,   14'd54,  14'd27
    };

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick generator: one-clk sample_ENABLE pulse every divisor period,
// restartable through clear so a new frame begins on a full tick.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_max;

    assign div_max       = BAUD_DIVISOR[baud_select] - DIV_W'(1);
    assign sample_ENABLE = (div_cnt == div_max);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            div_cnt <= '0;
        end else if (sample_ENABLE) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN for the 11-bit frame with parity; default is 10-bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam int TICK_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SAMPLES_PER_BIT - 1);

    uart_state_t       state, state_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic [2:0]        bit_cnt, bit_next, bit_inc;
    logic [7:0]        data_reg, data_next;
    logic [2:0]        baud_reg, baud_next;
    logic              txd_next, busy_next;
    logic              accept, sample_ENABLE, bit_end;

    // Divider runs off the latched baud code so mid-frame changes are invisible
    uart_baud_gen u_baud_gen (
        .clk           (clk),
        .reset         (reset),
        .clear         (accept),
        .baud_select   (baud_reg),
        .sample_ENABLE (sample_ENABLE)
    );

    assign bit_end = sample_ENABLE && (tick_cnt == TICK_MAX);
    assign bit_inc = bit_cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            data_reg <= '0;
            baud_reg <= '0;
            TxD      <= LINE_IDLE;
            Tx_BUSY  <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            data_reg <= data_next;
            baud_reg <= baud_next;
            TxD      <= txd_next;
            Tx_BUSY  <= busy_next;
        end
    end

    // TxD and Tx_BUSY are registered from the next state, so they change on
    // the same edge as the state itself.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        data_next  = data_reg;
        baud_next  = baud_reg;
        txd_next   = TxD;
        busy_next  = Tx_BUSY;
        accept     = 1'b0;

        if (state != IDLE && sample_ENABLE) begin
            tick_next = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        if (state != IDLE && !Tx_EN) begin
            state_next = IDLE;
            tick_next  = '0;
            bit_next   = '0;
            txd_next   = LINE_IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Tx_WR && Tx_EN) begin
                        accept     = 1'b1;
                        state_next = START;
                        tick_next  = '0;
                        bit_next   = '0;
                        data_next  = Tx_DATA;
                        baud_next  = baud_select;
                        txd_next   = START_LVL;
                        busy_next  = 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_next = DATA;
                        bit_next   = '0;
                        txd_next   = data_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
                            txd_next   = even_parity(data_reg);
`else
                            state_next = STOP;
                            txd_next   = STOP_LVL;
`endif
                        end else begin
                            bit_next = bit_inc;
                            txd_next = data_reg[bit_inc];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_next = STOP;
                        txd_next   = STOP_LVL;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_next = IDLE;
                        txd_next   = LINE_IDLE;
                        busy_next  = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    txd_next   = LINE_IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected frames,
// a monitor checks each frame as Tx_BUSY rises.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int SPB = 16;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          bw;
        int          busy_len;
        int          gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       Tx_EN;
    logic       TxD;
    logic       Tx_BUSY;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_fall = 0;
    exp_t exp_q[$];
    int   divs[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

    uart_transmitter #(.SAMPLES_PER_BIT(SPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic [10:0] f;
        f    = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9]  = ^d;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic push(input logic [7:0] d, input logic [2:0] b, input int nbits,
                        input bit full, input int gap);
        exp_t e;
        e.bits     = make_frame(d);
        e.nbits    = nbits;
        e.bw       = SPB * divs[b];
        e.busy_len = full ? NB * SPB * divs[b] : -1;
        e.gap      = gap;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] b);
        @(negedge clk);
        Tx_DATA     = d;
        baud_select = b;
        Tx_WR       = 1'b1;
        @(posedge clk);
        #1;
        Tx_WR = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (Tx_BUSY !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (Tx_BUSY !== 1'b0) check("wait_idle_timeout", Tx_BUSY, 0);
    endtask

    // Monitor: a rising Tx_BUSY starts a frame; bits are sampled mid-bit.
    initial begin : monitor
        exp_t e;
        logic prev_busy;
        int   start_cyc, elapsed, fall_at, limit;
        prev_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (Tx_BUSY === 1'b1 && prev_busy === 1'b0) begin
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    e = exp_q.pop_front();
                    check("start_level", TxD, 0);
                    if (e.gap >= 0) check("idle_gap", start_cyc - last_fall, e.gap);
                    elapsed = 0;
                    fall_at = -1;
                    for (int i = 0; i < e.nbits; i++) begin
                        while (elapsed < i * e.bw + e.bw / 2) begin
                            @(negedge clk);
                            elapsed++;
                            if (Tx_BUSY !== 1'b1 && fall_at < 0) fall_at = elapsed;
                        end
                        check($sformatf("frame_bit%0d", i), TxD, e.bits[i]);
                    end
                    limit = (e.busy_len >= 0) ? e.busy_len + 50 : 20000;
                    while (fall_at < 0 && elapsed < limit) begin
                        @(negedge clk);
                        elapsed++;
                        if (Tx_BUSY !== 1'b1) fall_at = elapsed;
                    end
                    if (fall_at < 0) begin
                        check("busy_fall_timeout", elapsed, limit + 1);
                    end else begin
                        last_fall = start_cyc + fall_at;
                        if (e.busy_len >= 0) check("busy_len", fall_at, e.busy_len);
                    end
                end
            end
            prev_busy = Tx_BUSY;
        end
    end

    initial begin : stimulus
        int n;
        reset       = 1'b0;
        baud_select = 3'b000;
        Tx_DATA     = 8'h00;
        Tx_WR       = 1'b0;
        Tx_EN       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", TxD, 1);
        check("reset_busy", Tx_BUSY, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5 at 115200; baud and data disturbed right after acceptance
        push(8'hA5, 3'b111, NB, 1'b1, -1);
        send(8'hA5, 3'b111);
        check("accept_txd", TxD, 0);
        check("accept_busy", Tx_BUSY, 1);
        baud_select = 3'b000;
        Tx_DATA     = 8'h00;
        wait_idle(6000);
        repeat (5) @(posedge clk);

        push(8'hFF, 3'b111, NB, 1'b1, -1);
        send(8'hFF, 3'b111);
        wait_idle(6000);
        repeat (5) @(posedge clk);

        push(8'h0F, 3'b110, NB, 1'b1, -1);
        send(8'h0F, 3'b110);
        wait_idle(12000);
        repeat (5) @(posedge clk);

        // Write during a frame is dropped
        push(8'h5A, 3'b111, NB, 1'b1, -1);
        send(8'h5A, 3'b111);
        repeat (1000) @(posedge clk);
        send(8'h3C, 3'b111);
        wait_idle(6000);
        repeat (20) @(posedge clk);
        #1;
        check("no_queue_busy", Tx_BUSY, 0);

        // Write while disabled is dropped
        Tx_EN = 1'b0;
        send(8'h77, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        check("disabled_busy", Tx_BUSY, 0);
        check("disabled_txd", TxD, 1);
        Tx_EN = 1'b1;

        // Tx_WR held high across the Tx_BUSY fall: back-to-back frames
        push(8'h81, 3'b111, NB, 1'b1, -1);
        push(8'hC3, 3'b111, NB, 1'b1, 1);
        @(negedge clk);
        Tx_DATA     = 8'h81;
        baud_select = 3'b111;
        Tx_WR       = 1'b1;
        @(posedge clk);
        #1;
        Tx_DATA = 8'hC3;
        wait_idle(6000);
        @(posedge clk);
        #1;
        Tx_WR = 1'b0;
        check("b2b_busy", Tx_BUSY, 1);
        wait_idle(6000);
        repeat (5) @(posedge clk);

        // Abort during DATA bit 3, then a clean frame
        push(8'h6B, 3'b111, 4, 1'b0, -1);
        send(8'h6B, 3'b111);
        repeat (4 * SPB * 27 + 200 - 1) @(posedge clk);
        #1;
        Tx_EN = 1'b0;
        @(posedge clk);
        #1;
        check("abort_txd", TxD, 1);
        check("abort_busy", Tx_BUSY, 0);
        Tx_EN = 1'b1;
        repeat (10) @(posedge clk);
        push(8'h96, 3'b111, NB, 1'b1, -1);
        send(8'h96, 3'b111);
        wait_idle(6000);
        repeat (5) @(posedge clk);

        // Reset pulse inside the start bit at 300 baud
        push(8'h55, 3'b000, 0, 1'b0, -1);
        send(8'h55, 3'b000);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midreset_txd", TxD, 1);
        check("midreset_busy", Tx_BUSY, 0);
        repeat (10) @(posedge clk);
        push(8'h01, 3'b111, NB, 1'b1, -1);
        send(8'h01, 3'b111);
        wait_idle(6000);

        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 16, meaning sample_ENABLE ticks per serial bit.
REQ-002 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
REQ-004 baud_select  input  3  baud rate code; latched at frame acceptance.
REQ-005 Tx_DATA  input  8  byte to send; latched at frame acceptance.
REQ-006 Tx_WR  input  1  write strobe; one-cycle request to send Tx_DATA.
REQ-007 Tx_EN  input  1  transmitter enable.
REQ-008 TxD  output  1  serial line; idle high.
REQ-009 Tx_BUSY  output  1  high while a frame is on the line.

Function
REQ-010 Frame SHALL be: start bit (0), Tx_DATA[0] to Tx_DATA[7] LSB first, parity bit, stop bit (1).
REQ-011 Baud codes 000..111 SHALL select 300/1200/4800/9600/19200/38400/57600/115200 baud, with divisors 10417/2604/651/326/163/81/54/27 clk per tick.
REQ-012 Each bit SHALL last exactly SAMPLES_PER_BIT ticks, which is SAMPLES_PER_BIT x divisor clk cycles.
REQ-013 State machine SHALL have the states IDLE, START, DATA, PARITY, and STOP.
REQ-014 Transitions SHALL be IDLE->START on acceptance, START->DATA, DATA->DATA for bits 0..6, DATA->PARITY after bit 7, PARITY->STOP, and STOP->IDLE, each at the end of its bit time.
REQ-015 Acceptance SHALL occur on the edge where Tx_WR=1, Tx_EN=1 and state=IDLE; Tx_DATA and baud_select are latched on that edge.
REQ-016 On the edge after acceptance, TxD SHALL be 0 and Tx_BUSY SHALL be 1 (one-cycle latency).
REQ-017 The tick divider SHALL be cleared at acceptance so the start bit is full length.
REQ-018 Tx_WR SHALL be ignored while Tx_BUSY=1 or Tx_EN=0; no queuing.
REQ-019 Tx_BUSY SHALL fall on the same edge that STOP ends, and TxD SHALL remain 1.
REQ-020 A Tx_WR sampled high on the cycle where Tx_BUSY is first 0 SHALL be accepted (back-to-back frames, zero idle gap).
REQ-021 If Tx_EN falls mid-frame, the next edge SHALL force state=IDLE, TxD=1 and Tx_BUSY=0 (abort).
REQ-022 A change of baud_select or Tx_DATA mid-frame SHALL NOT affect the current frame.
REQ-023 The bit counter SHALL be 3 bits and wrap 7->0 only on the DATA->PARITY transition.
REQ-024 The tick counter SHALL be log2(SAMPLES_PER_BIT) bits and wrap at SAMPLES_PER_BIT-1.

Reset
REQ-025 While reset=0 at a clk edge, the block SHALL set state=IDLE, TxD=1, Tx_BUSY=0, and clear the tick, bit and divider counters and latched data.
REQ-026 Reset asserted mid-frame SHALL take effect on that edge, with the line high on the next cycle.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, the PARITY state SHALL send even parity (XOR of the latched byte), giving an 11-bit frame.
REQ-028 Without UART_TX_PARITY_EN, PARITY SHALL be skipped (DATA->STOP), giving a 10-bit frame.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state enum typedef, the divisor table constants indexed by baud_select, and the idle/start/stop level constants; the receiver uses the same package.
REQ-030 Tick generation SHALL be the sub-module uart_baud_gen with ports clk, reset, clear, baud_select, and sample_ENABLE (a one-clk pulse per divisor period).

Verification
REQ-031 Parity build, baud_select=111, Tx_WR pulse with 0xA5 -> TxD = 0,1,0,1,0,0,1,0,1,0,1, each held 432 clk; Tx_BUSY high for 4752 clk.
REQ-032 No-parity build, 0xFF at baud 111 -> TxD = 0, eight 1s, stop 1; Tx_BUSY high for 4320 clk.
REQ-033 Tx_WR with 0x3C during a frame -> ignored; only the first byte appears on TxD.
REQ-034 Tx_WR held high across the Tx_BUSY fall -> second start bit begins 1 clk after Tx_BUSY falls; no idle gap.
REQ-035 Tx_EN=0 during DATA bit 3 -> next edge TxD=1 and Tx_BUSY=0; a later write sends a full, correct frame.
REQ-036 reset=0 for 1 cycle mid-START at baud 000 -> next cycle TxD=1 and Tx_BUSY=0; baud_select changed mid-frame -> bit width unchanged (10417x16 clk).
